req_resp_responder: RTL
=======================

REQ_RESP_RESPONDER -- requirements
Module: req_resp_responder

Interface
REQ-001 Parameter DATA_W, default 32: request write-data and response read-data width.
REQ-002 Parameter ADDR_W, default 7: request address width.
REQ-003 Parameter DEPTH, default 10: number of implemented storage words, legal range 1..2**ADDR_W.
REQ-004 Parameter LATENCY, default 2: cycles from request acceptance to rsp_valid, legal range 1..15.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 req_valid  input  1  initiator presents a request.
REQ-009 req_ready  output  1  responder accepts a request this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  response presented.
REQ-014 rsp_ready  input  1  initiator accepts the response.
REQ-015 rsp_rdata  output  DATA_W  read data, or written data echoed for writes.
REQ-016 rsp_err  output  1  address out of range (req_addr >= DEPTH).

Function
REQ-017 FSM states: IDLE, WAIT, RESP; exactly one transaction in flight at a time.
REQ-018 IDLE: req_ready=1, rsp_valid=0; req_valid&&req_ready -> capture write/addr/wdata, load countdown with LATENCY-1, go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-019 WAIT: req_ready=0; countdown decrements each cycle; at 0 -> RESP.
REQ-020 Net latency: rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-021 RESP: rsp_valid=1; rsp_rdata/rsp_err stable while rsp_ready=0; rsp_valid&&rsp_ready -> IDLE.
REQ-022 No back-to-back overlap: req_ready is 0 in the handshake cycle of RESP; a new request is accepted at the earliest in the cycle after the response handshake.
REQ-023 Write in range: storage word updated at acceptance edge; response rsp_rdata=wdata, rsp_err=0.
REQ-024 Read in range: rsp_rdata = storage word value at acceptance edge, rsp_err=0.
REQ-025 Out of range (addr >= DEPTH): no storage update, rsp_rdata=0, rsp_err=1.
REQ-026 Address compare is unsigned, at full ADDR_W width; no wrap/aliasing onto low addresses.
REQ-027 Inputs req_write/addr/wdata ignored whenever req_ready=0.

Reset
REQ-028 Reset values: state=IDLE, req_ready=1 once rst deasserts (0 while rst high), rsp_valid=0, rsp_rdata=0, rsp_err=0, countdown=0.
REQ-029 Storage words reset to 0.
REQ-030 Reset asserted in WAIT or RESP discards the in-flight transaction; no response is issued after deassertion.

Structure
REQ-031 Shared package holds the FSM state enum and parameter defaults (DATA_W, ADDR_W, DEPTH, LATENCY).
REQ-032 Storage is a sub-module resp_regfile (DEPTH x DATA_W, one sync write port, one async read port, async reset to 0).
REQ-033 Elaboration check: DEPTH > 2**ADDR_W or LATENCY outside 1..15 is a fatal elaboration error.

Verification
REQ-034 Reset, then write addr 3 data 0x0000_00A5, rsp_ready=1 -> rsp_valid exactly 2 cycles after acceptance, rdata=0xA5, err=0.
REQ-035 Read addr 3 after REQ-034 -> rdata=0xA5; read addr 4 -> rdata=0.
REQ-036 Read addr 10 (=DEPTH) and addr 127 -> err=1, rdata=0; a following read of addr 2 returns 0 (no alias writes).
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata, err stable; req_ready=0 throughout; second request accepted only after the handshake.
REQ-038 Assert rst during WAIT -> rsp_valid never rises; subsequent read of written address returns 0.
REQ-039 Override DEPTH=100, LATENCY=1 -> write addr 99 accepted with err=0, response 1 cycle after acceptance; addr 100 -> err=1.

Source files
------------

// File: rtl/req_resp_responder_pkg.sv
// Shared types and parameter defaults for the request/response responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package req_resp_responder_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 7;
    localparam int DEF_DEPTH   = 10;
    localparam int DEF_LATENCY = 2;

    // Countdown register width; LATENCY-1 never exceeds 14.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/resp_regfile.sv
// DEPTH x DATA_W storage with one synchronous write port and one asynchronous read port.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; caller gates the write enable (including address range).
module resp_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Word update on write; full-width address match so nothing aliases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_waddr == ADDR_W'(i)) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Read mux; unmatched (out-of-range) addresses return zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_raddr == ADDR_W'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/req_resp_responder.sv
// Single-outstanding request/response responder in front of a small register file.
// Latency: rsp_valid rises LATENCY cycles after the request is accepted.
// Backpressure: response held stable until rsp_ready; no new request accepted until after that handshake.
module req_resp_responder
    import req_resp_responder_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || LATENCY < 1 || LATENCY > 15) begin : g_param_check
        $fatal(1, "req_resp_responder: DEPTH must be 1..2**ADDR_W and LATENCY 1..15");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic               w_accept;
    logic               w_in_range;
    logic               w_we;
    logic [DATA_W-1:0]  w_rd_word;

    // Unsigned compare one bit wider than the address so DEPTH == 2**ADDR_W fits.
    assign w_in_range = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
    assign w_we       = w_accept & req_write & w_in_range;

    resp_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (req_addr),
        .i_wdata (req_wdata),
        .i_raddr (req_addr),
        .o_rdata (w_rd_word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs; req_ready held low while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = ~rst;
                w_accept  = req_valid & ~rst;
                if (w_accept) begin
                    w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter reaches zero on the same edge that enters RESP.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the response at acceptance so it stays stable however long RESP is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_err   <= ~w_in_range;
            r_rdata <= !w_in_range ? '0 : (req_write ? req_wdata : w_rd_word);
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
